// File: rtl/dsp_postadd_preg.sv
// Post-adder, P register, PCOUT cascade and frame accumulate controller of a DSP48A1-style slice.
// Latency IREG+PREG; no backpressure, stages stall on ce_in/ce_p; DSP_POSTADD_SAT_EN adds saturation and sat_flag.
module dsp_postadd_preg #(
   parameter int IREG    = 1,
   parameter int PREG    = 1,
   parameter int WIDTH_M = 36,
   parameter int WIDTH_P = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce_in,
   input  logic               ce_p,
   input  logic [4:0]         opmode,
   input  logic [WIDTH_M-1:0] m_in,
   input  logic [WIDTH_P-1:0] dab_in,
   input  logic [WIDTH_P-1:0] c_in,
   input  logic [WIDTH_P-1:0] pcin,
   input  logic               carryin,
   input  logic               valid_in,
   input  logic [15:0]        frame_len,
   output logic [WIDTH_P-1:0] p,
   output logic [WIDTH_P-1:0] pcout,
   output logic               carryout,
   output logic               valid_out,
   output logic               frame_done
`ifdef DSP_POSTADD_SAT_EN
   ,
   output logic               sat_flag
`endif
);

   typedef enum logic {ACCUM, RESTART} frame_state_t;

   logic [4:0]         s1_opmode;
   logic [WIDTH_M-1:0] s1_m;
   logic [WIDTH_P-1:0] s1_dab;
   logic [WIDTH_P-1:0] s1_c;
   logic [WIDTH_P-1:0] s1_pcin;
   logic               s1_cin;
   logic               s1_vld;

   frame_state_t       state, state_nxt;
   logic [15:0]        cnt, cnt_nxt, cnt_upd;
   logic               p_load, fb_zero, frame_end;

   logic [WIDTH_P-1:0] p_fb, x_op, z_op, p_res;
   logic [WIDTH_P:0]   sum;
   logic               sub, co_nxt;

   generate
      if (IREG != 0) begin : g_ireg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_opmode <= '0;
               s1_m      <= '0;
               s1_dab    <= '0;
               s1_c      <= '0;
               s1_pcin   <= '0;
               s1_cin    <= 1'b0;
               s1_vld    <= 1'b0;
            end else if (ce_in) begin
               s1_opmode <= opmode;
               s1_m      <= m_in;
               s1_dab    <= dab_in;
               s1_c      <= c_in;
               s1_pcin   <= pcin;
               s1_cin    <= carryin;
               s1_vld    <= valid_in;
            end
         end
      end else begin : g_noireg
         assign s1_opmode = opmode;
         assign s1_m      = m_in;
         assign s1_dab    = dab_in;
         assign s1_c      = c_in;
         assign s1_pcin   = pcin;
         assign s1_cin    = carryin;
         assign s1_vld    = valid_in;
      end
   endgenerate

   // Only valid samples reach the accumulator and advance the frame counter.
   assign p_load = ce_p & s1_vld;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cnt_upd   = 16'd0;
      fb_zero   = 1'b0;
      frame_end = 1'b0;
      if (frame_len == 16'd0) begin
         if (p_load) begin
            state_nxt = ACCUM;
            cnt_nxt   = 16'd0;
         end
      end else begin
         fb_zero   = (state == RESTART);
         cnt_upd   = fb_zero ? 16'd1 : cnt + 16'd1;
         // A wrap to zero closes a frame whose length was shrunk below the running count.
         frame_end = (cnt_upd == frame_len) || (cnt_upd == 16'd0);
         if (p_load) begin
            state_nxt = frame_end ? RESTART : ACCUM;
            cnt_nxt   = frame_end ? 16'd0 : cnt_upd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESTART;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      x_op = '0;
      z_op = '0;
      case (s1_opmode[1:0])
         2'd1:    x_op = {{(WIDTH_P-WIDTH_M){1'b0}}, s1_m};
         2'd2:    x_op = p_fb;
         2'd3:    x_op = s1_dab;
         default: x_op = '0;
      endcase
      case (s1_opmode[3:2])
         2'd1:    z_op = s1_pcin;
         2'd2:    z_op = p_fb;
         2'd3:    z_op = s1_c;
         default: z_op = '0;
      endcase
   end

   always_comb begin
      sub = s1_opmode[4];
      if (sub) begin
         sum = {1'b0, z_op} - ({1'b0, x_op} + {{WIDTH_P{1'b0}}, s1_cin});
      end else begin
         sum = {1'b0, z_op} + {1'b0, x_op} + {{WIDTH_P{1'b0}}, s1_cin};
      end
      co_nxt = sub ? ~sum[WIDTH_P] : sum[WIDTH_P];
`ifdef DSP_POSTADD_SAT_EN
      if (sum[WIDTH_P]) begin
         p_res = sub ? '0 : '1;
      end else begin
         p_res = sum[WIDTH_P-1:0];
      end
`else
      p_res = sum[WIDTH_P-1:0];
`endif
   end

   generate
      if (PREG != 0) begin : g_preg
         logic [WIDTH_P-1:0] p_q;
         logic               co_q, vld_q, done_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               p_q    <= '0;
               co_q   <= 1'b0;
               vld_q  <= 1'b0;
               done_q <= 1'b0;
            end else if (ce_p) begin
               vld_q <= s1_vld;
               if (s1_vld) begin
                  p_q    <= p_res;
                  co_q   <= co_nxt;
                  done_q <= frame_end;
               end
            end
         end

         assign p_fb       = fb_zero ? '0 : p_q;
         assign p          = p_q;
         assign carryout   = co_q;
         assign valid_out  = vld_q;
         assign frame_done = done_q;
      end else begin : g_nopreg
         // Without a P register there is nothing to feed back.
         assign p_fb       = '0;
         assign p          = p_res;
         assign carryout   = co_nxt;
         assign valid_out  = s1_vld;
         assign frame_done = p_load & frame_end;
      end
   endgenerate

   assign pcout = p;

`ifdef DSP_POSTADD_SAT_EN
   logic sat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else if (p_load & sum[WIDTH_P]) begin
         sat_q <= 1'b1;
      end
   end

   assign sat_flag = sat_q | ((PREG == 0) & p_load & sum[WIDTH_P]);
`endif

endmodule
